// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Single-outstanding instruction fetcher feeding a DEPTH-entry
//            {pc, instr} queue that drains into the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_fetch_pc;
  logic [31:0]          r_tag;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic [31:0]          r_pc_q    [DEPTH];
  logic [31:0]          r_instr_q [DEPTH];

  logic                 w_req;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_valid;

  // Request is gated by rst_n so nothing is asserted while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req    = rst_n && (r_count < c_depth);
        w_accept = w_req && imem_ready;
        if (w_accept) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_push = imem_rvalid;
        if (imem_rvalid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_valid = (r_count != '0);
  assign w_pop   = pc_write && w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_tag      <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_tag      <= r_fetch_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]    <= r_tag;
      r_instr_q[r_wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = w_valid;
  assign instr_out   = w_valid ? r_instr_q[r_rd_ptr] : 32'h0000_0000;
  assign pc_out      = w_valid ? r_pc_q[r_rd_ptr]    : r_fetch_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req,   imem_req_w;
  logic [31:0] imem_addr,  imem_addr_w;
  logic [31:0] instr_out,  instr_out_w;
  logic [31:0] pc_out,     pc_out_w;
  logic        instr_valid, instr_valid_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  // Second instance sees identical handshakes but starts near the top of memory.
  instr_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(instr_out_w), .pc_out(pc_out_w), .instr_valid(instr_valid_w)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One request/response round trip at address a; mid_valid is the expected
  // instr_valid right after the accept edge.
  task automatic fetch_one(input logic [31:0] a, input logic mid_valid);
    check("req_before_accept", {31'd0, imem_req}, 32'd1);
    check("addr", imem_addr, a);
    check("addr_wrap", imem_addr_w, a + WRAP_PC);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("req_in_wait", {31'd0, imem_req}, 32'd0);
    check("valid_after_accept", {31'd0, instr_valid}, {31'd0, mid_valid});
    imem_rvalid = 1'b1;
    imem_rdata  = word_at(a);
    tick();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    pc_write    = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_pc_wrap", pc_out_w, WRAP_PC);

    // Release: request immediately at RESET_PC, then stall on imem_ready=0
    rst_n = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, 32'h0);
      check("stall_pc_out", pc_out, 32'h0);
      check("stall_addr_wrap", imem_addr_w, WRAP_PC);
    end

    // Fill the queue with pc_write=0
    fetch_one(32'h0, 1'b0);
    check("first_valid", {31'd0, instr_valid}, 32'd1);
    check("first_instr", instr_out, word_at(32'h0));
    fetch_one(32'h4, 1'b1);
    fetch_one(32'h8, 1'b1);
    fetch_one(32'hC, 1'b1);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_req", {31'd0, imem_req}, 32'd0);
      check("full_instr", instr_out, word_at(32'h0));
      check("full_pc", pc_out, 32'h0);
    end
    imem_ready = 1'b0;
    check("full_pc_wrap", pc_out_w, WRAP_PC);

    // One pop frees a slot: next request at 0x10
    pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
    check("pop_req", {31'd0, imem_req}, 32'd1);
    check("pop_addr", imem_addr, 32'h10);
    check("pop_pc", pc_out, 32'h4);
    check("pop_instr", instr_out, word_at(32'h4));
    check("pop_addr_wrap", imem_addr_w, 32'h8);

    // Reset while a request is outstanding; late response must be dropped
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("wait_req", {31'd0, imem_req}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_instr", instr_out, 32'h0);
    check("midrst_pc", pc_out, 32'h0);
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("rerst_req", {31'd0, imem_req}, 32'd1);
    check("rerst_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0;
    check("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    check("late_rvalid_req", {31'd0, imem_req}, 32'd1);
    check("late_rvalid_addr", imem_addr, 32'h0);

    // Streaming with pc_write=1: one instruction every two cycles, in order
    pc_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_one(32'(i * 4), 1'b0);
      check("stream_valid", {31'd0, instr_valid}, 32'd1);
      check("stream_instr", instr_out, word_at(32'(i * 4)));
      check("stream_pc", pc_out, 32'(i * 4));
    end
    tick();
    check("drain_valid", {31'd0, instr_valid}, 32'd0);
    check("drain_instr", instr_out, 32'h0);
    check("drain_pc", pc_out, 32'h18);
    pc_write = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
